ew_gate_join_mul: RTL and testbench
===================================

// Module: ew_gate_join_mul
// PURPOSE
//  Output-gate receiver for the EW update path: buffers state tiles s, joins each with one
//  gate tile g arriving on g_axis in strict token order, and emits y = s (.) g (lane-wise Q8.8).
//  Sits after the EW update stage; g_axis is fed by the external gate-token transmitter, y_axis
//  drives the downstream consumer.
// PARAMETERS
//  TILE_SIZE    4   lanes per tile
//  DATA_WIDTH   16  signed lane width (s, g, y)
//  G_FRAC_BITS  8   fractional bits of g; product is shifted right by this amount
//  S_ADDR_W     6   s buffer address width; depth = 2**S_ADDR_W (64)
//  SATURATE     0   0: wrap (take bits [G_FRAC_BITS+:DATA_WIDTH]); 1: clamp to signed range
// PORTS
//  clk            in   1                      clock, all logic on posedge
//  rst            in   1                      async reset, active-high
//  s_in_valid     in   1                      state tile valid
//  s_in_ready     out  1                      state tile accept (= !full)
//  s_in_data      in   [TILE_SIZE][DW] signed state tile
//  g_axis_TVALID  in   1                      gate tile valid
//  g_axis_TREADY  out  1                      gate tile accept
//  g_axis_TDATA   in   [TILE_SIZE][DW] signed gate tile, Q(DW-G_FRAC_BITS).G_FRAC_BITS
//  y_axis_TVALID  out  1                      gated tile valid
//  y_axis_TREADY  in   1                      downstream accept
//  y_axis_TDATA   out  [TILE_SIZE][DW] signed gated tile
//  s_level        out  S_ADDR_W+1             s buffer occupancy
//  y_tok_cnt      out  32                     count of y fires since reset
// BEHAVIOUR
//  Reset (rst=1, asynchronous): wr/rd ptrs=0, s_level=0, y_axis_TVALID=0, y_axis_TDATA=0,
//   y_tok_cnt=0; s_in_ready=1 and g_axis_TREADY=0 follow combinationally from empty state.
//  Reset mid-operation drops all queued s and any held y; no token survives.
//  s buffer: circular FIFO, ptrs S_ADDR_W+1 bits (MSB = wrap bit); full when addr equal, wrap differs.
//   s_fire = s_in_valid & s_in_ready -> write at wr_ptr, wr_ptr++.
//   No write-through: an s written in cycle N is poppable from cycle N+1 at earliest.
//  Output stage: single register; stage_free = !y_axis_TVALID | y_axis_TREADY.
//  g_axis_TREADY = (s_level != 0) & stage_free (combinational; no dependence on TVALID).
//  g_fire = g_axis_TVALID & g_axis_TREADY -> pop s head, rd_ptr++, compute lane products,
//   load y register, y_axis_TVALID=1 at next edge (latency 1 cycle from g_fire).
//  y_fire without g_fire -> y_axis_TVALID=0; y_fire with g_fire -> new data replaces old, stays 1.
//  y_axis_TVALID=1 & TREADY=0: TDATA held stable, g_axis_TREADY=0.
//  Simultaneous s_fire & g_fire: s_level unchanged; legal at any level incl. full-1 (not at full).
//  s_level = wr_ptr - rd_ptr; s_in_ready=0 exactly when s_level == 2**S_ADDR_W.
//  Arithmetic per lane: prod = s*g (signed 2*DW bits, full precision).
//   SATURATE=0: y = prod[G_FRAC_BITS +: DW] (arithmetic floor, wraps on overflow).
//   SATURATE=1: q = prod >>> G_FRAC_BITS; y = clamp(q, -2**(DW-1), 2**(DW-1)-1).
//  Ordering: the k-th g fire always pairs with the k-th s fire; y order == s order.
//  g arriving with buffer empty is stalled (TREADY=0), never dropped or paired later out of order.
//  y_tok_cnt increments on each y fire, wraps at 2**32.
// TESTING
//  T1 reset: assert rst mid-clock -> immediately y_axis_TVALID=0, s_level=0, s_in_ready=1, g_axis_TREADY=0.
//  T2 unity gate: s={0x0100,0x0200,-0x0100,0x03E8}, g=0x0100 all lanes -> y==s exactly 1 cycle after g_fire.
//  T3 scaling/floor: s=0x0300,g=0x0110 -> y=0x0330; s=-256,g=0x0180 -> y=-384; s=1,g=0x0080 -> 0;
//     s=-1,g=0x0080 -> -1.
//  T4 full/wrap: push 64 s tiles, no g -> s_level=64, s_in_ready=0; 3 token rounds of 64 via wrap,
//     g pattern 0x0100+(tok<<4)+(lane<<3) -> every y matches model, order preserved, y_tok_cnt=192.
//  T5 back-pressure: y_axis_TREADY=0 for 20 cycles with g_axis_TVALID=1 -> exactly one y held stable,
//     g_axis_TREADY=0, no g lost; release -> next y 1 cycle later; simultaneous s/g fire keeps s_level.
//  T6 saturation: s=0x7FFF,g=0x0200 -> SATURATE=1: 0x7FFF, SATURATE=0: 0xFFFE; s=-0x8000,g=0x0200
//     -> SATURATE=1: -0x8000; plus rst with 10 queued -> s_level=0, queued tokens never emerge.

Source files
------------

// File: rtl/ew_gate_join_mul_if.sv
// ew_gate_join_mul_if
//  Handshake bundle for the EW output-gate receiver.
//  It carries three streams:
//   - the state-tile input (s_in_*),
//   - the gate-tile input (g_axis_*),
//   - the gated-tile output (y_axis_*).
//  Modports:
//   slave  : the receiver side. It consumes s and g and produces y.
//   master : the environment side. It produces s and g and consumes y.
//  Tiles are packed [TILE_SIZE][DATA_WIDTH]. Lane 0 sits in the least significant bits.
interface ew_gate_join_mul_if #(
    parameter int TILE_SIZE  = 4,
    parameter int DATA_WIDTH = 16
);
    logic                                   s_in_valid;
    logic                                   s_in_ready;
    logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]   s_in_data;

    logic                                   g_axis_TVALID;
    logic                                   g_axis_TREADY;
    logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]   g_axis_TDATA;

    logic                                   y_axis_TVALID;
    logic                                   y_axis_TREADY;
    logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]   y_axis_TDATA;

    modport slave (
        input  s_in_valid, s_in_data,
        output s_in_ready,
        input  g_axis_TVALID, g_axis_TDATA,
        output g_axis_TREADY,
        output y_axis_TVALID, y_axis_TDATA,
        input  y_axis_TREADY
    );

    modport master (
        output s_in_valid, s_in_data,
        input  s_in_ready,
        output g_axis_TVALID, g_axis_TDATA,
        input  g_axis_TREADY,
        input  y_axis_TVALID, y_axis_TDATA,
        output y_axis_TREADY
    );
endinterface

// File: rtl/ew_gate_join_mul.sv
// ew_gate_join_mul
//  Output-gate receiver for the EW update path.
//  - Buffers state tiles s in a circular FIFO.
//  - Pairs the k-th buffered s with the k-th gate tile g, in strict token order.
//  - Registers y = s (.) g, computed lane-wise in Q8.8.
//  Ports:
//   clk       : clock, posedge.
//   rst       : asynchronous reset, active-high. It drops every queued token.
//   bus       : ew_gate_join_mul_if.slave.
//               s_in_* carries state tiles in; g_axis_* carries gate tiles in;
//               y_axis_* carries gated tiles out.
//   s_level   : occupancy of the s buffer (0 .. 2**S_ADDR_W).
//   y_tok_cnt : number of y handshakes since reset. It wraps at 2**32.
module ew_gate_join_mul #(
    parameter int TILE_SIZE   = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int G_FRAC_BITS = 8,
    parameter int S_ADDR_W    = 6,
    parameter int SATURATE    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    ew_gate_join_mul_if.slave    bus,
    output logic [S_ADDR_W:0]    s_level,
    output logic [31:0]          y_tok_cnt
);
    localparam int LP_DEPTH = 2**S_ADDR_W;

    typedef logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] tile_t;

    // Signed range of one output lane, widened to the product width for the clamp compare.
    localparam logic signed [2*DATA_WIDTH-1:0] LP_Q_MAX =
        {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [2*DATA_WIDTH-1:0] LP_Q_MIN =
        {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // One lane: full-precision signed product, then floor-shift by the gate fraction.
    //  Wrap mode  : keep the DATA_WIDTH bits above the fraction.
    //  Clamp mode : saturate to the signed lane range.
    function automatic logic [DATA_WIDTH-1:0] f_gate_lane(
        input logic signed [DATA_WIDTH-1:0] s_val,
        input logic signed [DATA_WIDTH-1:0] g_val
    );
        logic signed [2*DATA_WIDTH-1:0] prod;
        logic signed [2*DATA_WIDTH-1:0] q;
        logic        [DATA_WIDTH-1:0]   res;
        prod = s_val * g_val;
        q    = prod >>> G_FRAC_BITS;
        if (SATURATE != 0) begin
            if (q > LP_Q_MAX) begin
                res = LP_Q_MAX[DATA_WIDTH-1:0];
            end else if (q < LP_Q_MIN) begin
                res = LP_Q_MIN[DATA_WIDTH-1:0];
            end else begin
                res = q[DATA_WIDTH-1:0];
            end
        end else begin
            res = prod[G_FRAC_BITS +: DATA_WIDTH];
        end
        return res;
    endfunction

    tile_t               r_mem [LP_DEPTH];
    logic [S_ADDR_W:0]   r_wr_ptr;
    logic [S_ADDR_W:0]   r_rd_ptr;
    logic                r_y_valid;
    tile_t               r_y_data;
    logic [31:0]         r_tok_cnt;

    logic                w_full;
    logic                w_stage_free;
    logic                w_g_ready;
    logic                w_s_fire;
    logic                w_g_fire;
    logic                w_y_fire;
    logic [S_ADDR_W:0]   w_level;
    tile_t               w_head;
    tile_t               w_prod_tile;

    // The pointers carry one extra wrap bit.
    // Full means: same address, different lap.
    assign w_full       = (r_wr_ptr[S_ADDR_W] != r_rd_ptr[S_ADDR_W]) &&
                          (r_wr_ptr[S_ADDR_W-1:0] == r_rd_ptr[S_ADDR_W-1:0]);
    assign w_level      = r_wr_ptr - r_rd_ptr;
    assign w_stage_free = !r_y_valid || bus.y_axis_TREADY;
    // g is only taken when an s is already stored.
    // An s written this cycle is not visible until the next one.
    assign w_g_ready    = (w_level != {(S_ADDR_W+1){1'b0}}) && w_stage_free;
    assign w_s_fire     = bus.s_in_valid && !w_full;
    assign w_g_fire     = bus.g_axis_TVALID && w_g_ready;
    assign w_y_fire     = r_y_valid && bus.y_axis_TREADY;
    assign w_head       = r_mem[r_rd_ptr[S_ADDR_W-1:0]];

    assign bus.s_in_ready    = !w_full;
    assign bus.g_axis_TREADY = w_g_ready;
    assign bus.y_axis_TVALID = r_y_valid;
    assign bus.y_axis_TDATA  = r_y_data;
    assign s_level           = w_level;
    assign y_tok_cnt         = r_tok_cnt;

    // Lane-wise gating of the buffered head tile by the incoming gate tile.
    always_comb begin
        w_prod_tile = '0;
        for (int i = 0; i < TILE_SIZE; i++) begin
            w_prod_tile[i] = f_gate_lane(w_head[i], bus.g_axis_TDATA[i]);
        end
    end

    // State-tile storage.
    // It needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_s_fire) begin
            r_mem[r_wr_ptr[S_ADDR_W-1:0]] <= bus.s_in_data;
        end
    end

    // FIFO pointers.
    // A simultaneous push and pop leaves the occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {(S_ADDR_W+1){1'b0}};
            r_rd_ptr <= {(S_ADDR_W+1){1'b0}};
        end else begin
            if (w_s_fire) begin
                r_wr_ptr <= r_wr_ptr + (S_ADDR_W+1)'(1);
            end
            if (w_g_fire) begin
                r_rd_ptr <= r_rd_ptr + (S_ADDR_W+1)'(1);
            end
        end
    end

    // Single output register.
    //  - A pairing loads it, even in the same cycle the old y leaves.
    //  - An unaccepted y holds its data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y_valid <= 1'b0;
            r_y_data  <= '0;
        end else if (w_g_fire) begin
            r_y_valid <= 1'b1;
            r_y_data  <= w_prod_tile;
        end else if (w_y_fire) begin
            r_y_valid <= 1'b0;
        end else begin
            r_y_valid <= r_y_valid;
        end
    end

    // Count of y tokens delivered downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tok_cnt <= 32'd0;
        end else if (w_y_fire) begin
            r_tok_cnt <= r_tok_cnt + 32'd1;
        end else begin
            r_tok_cnt <= r_tok_cnt;
        end
    end
endmodule

// File: tb/tb_ew_gate_join_mul.sv
module tb_ew_gate_join_mul;
    localparam int TS = 4;
    localparam int DW = 16;
    localparam int FB = 8;
    localparam int AW = 6;

    typedef logic [TS-1:0][DW-1:0] tile_t;
    typedef struct { string name; tile_t s; tile_t g; tile_t exp_wrap; tile_t exp_sat; } vec_t;
    typedef struct { tile_t wrap; tile_t sat; } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ew_gate_join_mul_if #(.TILE_SIZE(TS), .DATA_WIDTH(DW)) bus0 ();
    ew_gate_join_mul_if #(.TILE_SIZE(TS), .DATA_WIDTH(DW)) bus1 ();
    logic [AW:0] lvl0, lvl1;
    logic [31:0] cnt0, cnt1;

    ew_gate_join_mul #(.TILE_SIZE(TS), .DATA_WIDTH(DW), .G_FRAC_BITS(FB), .S_ADDR_W(AW), .SATURATE(0))
        u_wrap (.clk(clk), .rst(rst), .bus(bus0), .s_level(lvl0), .y_tok_cnt(cnt0));
    ew_gate_join_mul #(.TILE_SIZE(TS), .DATA_WIDTH(DW), .G_FRAC_BITS(FB), .S_ADDR_W(AW), .SATURATE(1))
        u_sat (.clk(clk), .rst(rst), .bus(bus1), .s_level(lvl1), .y_tok_cnt(cnt1));

    // The saturating instance sees exactly the same stimulus as the wrapping one.
    assign bus1.s_in_valid    = bus0.s_in_valid;
    assign bus1.s_in_data     = bus0.s_in_data;
    assign bus1.g_axis_TVALID = bus0.g_axis_TVALID;
    assign bus1.g_axis_TDATA  = bus0.g_axis_TDATA;
    assign bus1.y_axis_TREADY = bus0.y_axis_TREADY;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic tile_t mk(input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] c, input logic [15:0] d);
        tile_t t;
        t[0] = a; t[1] = b; t[2] = c; t[3] = d;
        return t;
    endfunction

    // Reference arithmetic: exact integer product, floor shift, then wrap or clamp.
    function automatic exp_t model(input tile_t s, input tile_t g);
        exp_t r;
        longint p;
        longint q;
        for (int i = 0; i < TS; i++) begin
            p = longint'($signed(s[i])) * longint'($signed(g[i]));
            q = p >>> FB;
            r.wrap[i] = q[15:0];
            if (q > 64'sd32767)       r.sat[i] = 16'h7FFF;
            else if (q < -64'sd32768) r.sat[i] = 16'h8000;
            else                      r.sat[i] = q[15:0];
        end
        return r;
    endfunction

    // Scoreboard.
    //  - Every s handshake is queued.
    //  - Every g handshake pops the oldest s and queues the expected y.
    //  - Every y handshake is compared with the oldest expected y.
    tile_t m_s[$];
    exp_t  m_y[$];
    exp_t  mon_e;
    tile_t mon_st;

    always @(negedge clk) begin
        if (rst) begin
            m_s.delete();
            m_y.delete();
        end else begin
            check("s_level", 64'(lvl0), 64'(m_s.size()));
            check("s_level_sat", 64'(lvl1), 64'(m_s.size()));
            check("y_valid", 64'(bus0.y_axis_TVALID), 64'(m_y.size() != 0));
            check("y_valid_sat", 64'(bus1.y_axis_TVALID), 64'(m_y.size() != 0));
            if (bus0.y_axis_TVALID && bus0.y_axis_TREADY) begin
                check("y_expected", 64'(m_y.size() != 0), 64'd1);
                if (m_y.size() != 0) begin
                    mon_e = m_y.pop_front();
                    check("y_wrap", bus0.y_axis_TDATA, mon_e.wrap);
                    check("y_sat", bus1.y_axis_TDATA, mon_e.sat);
                end
            end
            if (bus0.g_axis_TVALID && bus0.g_axis_TREADY) begin
                check("g_has_s", 64'(m_s.size() != 0), 64'd1);
                if (m_s.size() != 0) begin
                    mon_st = m_s.pop_front();
                    m_y.push_back(model(mon_st, bus0.g_axis_TDATA));
                end
            end
            if (bus0.s_in_valid && bus0.s_in_ready) m_s.push_back(bus0.s_in_data);
        end
    end

    // Both send tasks start and end just after a rising edge.
    task automatic send_s(input tile_t t);
        int n = 0;
        bus0.s_in_data = t;
        bus0.s_in_valid = 1'b1;
        @(negedge clk);
        while (!bus0.s_in_ready && n < 400) begin n++; @(negedge clk); end
        check("s_accept_in_time", 64'(n < 400), 64'd1);
        @(posedge clk); #1;
        bus0.s_in_valid = 1'b0;
    endtask

    task automatic send_g(input tile_t t);
        int n = 0;
        bus0.g_axis_TDATA = t;
        bus0.g_axis_TVALID = 1'b1;
        @(negedge clk);
        while (!bus0.g_axis_TREADY && n < 400) begin n++; @(negedge clk); end
        check("g_accept_in_time", 64'(n < 400), 64'd1);
        @(posedge clk); #1;
        bus0.g_axis_TVALID = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (m_y.size() != 0 && n < 100) begin n++; @(negedge clk); end
        check("drain_in_time", 64'(n < 100), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t  vecs[4];
    tile_t t5_s[3];
    tile_t ga, gb, gc, gx, s_new;
    exp_t  e;

    initial begin
        vecs[0] = '{"unity", mk(16'h0100, 16'h0200, 16'hFF00, 16'h03E8),
                    mk(16'h0100, 16'h0100, 16'h0100, 16'h0100),
                    mk(16'h0100, 16'h0200, 16'hFF00, 16'h03E8),
                    mk(16'h0100, 16'h0200, 16'hFF00, 16'h03E8)};
        vecs[1] = '{"floor", mk(16'h0300, 16'hFF00, 16'h0001, 16'hFFFF),
                    mk(16'h0110, 16'h0180, 16'h0080, 16'h0080),
                    mk(16'h0330, 16'hFE80, 16'h0000, 16'hFFFF),
                    mk(16'h0330, 16'hFE80, 16'h0000, 16'hFFFF)};
        vecs[2] = '{"saturate", mk(16'h7FFF, 16'h8000, 16'h8000, 16'h0100),
                    mk(16'h0200, 16'h0200, 16'h8000, 16'h0100),
                    mk(16'hFFFE, 16'h0000, 16'h0000, 16'h0100),
                    mk(16'h7FFF, 16'h8000, 16'h7FFF, 16'h0100)};
        vecs[3] = '{"mixed", mk(16'h0180, 16'h0001, 16'h1234, 16'h4000),
                    mk(16'hFF00, 16'hFFFF, 16'h0000, 16'h0400),
                    mk(16'hFE80, 16'hFFFF, 16'h0000, 16'h0000),
                    mk(16'hFE80, 16'hFFFF, 16'h0000, 16'h7FFF)};

        rst = 1'b1;
        bus0.s_in_valid = 1'b0; bus0.s_in_data = '0;
        bus0.g_axis_TVALID = 1'b0; bus0.g_axis_TDATA = '0;
        bus0.y_axis_TREADY = 1'b1;
        @(negedge clk);
        check("rst_y_valid", 64'(bus0.y_axis_TVALID), 64'd0);
        check("rst_y_data", bus0.y_axis_TDATA, 64'd0);
        check("rst_s_level", 64'(lvl0), 64'd0);
        check("rst_s_ready", 64'(bus0.s_in_ready), 64'd1);
        check("rst_g_ready", 64'(bus0.g_axis_TREADY), 64'd0);
        check("rst_tok_cnt", 64'(cnt0), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table vectors: y must appear exactly one cycle after the g handshake.
        for (int i = 0; i < 4; i++) begin
            send_s(vecs[i].s);
            send_g(vecs[i].g);
            @(negedge clk);
            check({vecs[i].name, "_latency"}, 64'(bus0.y_axis_TVALID), 64'd1);
            check({vecs[i].name, "_wrap"}, bus0.y_axis_TDATA, vecs[i].exp_wrap);
            check({vecs[i].name, "_sat"}, bus1.y_axis_TDATA, vecs[i].exp_sat);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("tok_cnt_table", 64'(cnt0), 64'd4);
        @(posedge clk); #1;

        // Asynchronous reset mid-cycle while a y is held and s tiles are queued.
        send_s(mk(16'h0100, 16'h0100, 16'h0100, 16'h0100));
        send_s(mk(16'h0200, 16'h0200, 16'h0200, 16'h0200));
        bus0.y_axis_TREADY = 1'b0;
        send_g(mk(16'h0100, 16'h0100, 16'h0100, 16'h0100));
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_y_valid", 64'(bus0.y_axis_TVALID), 64'd0);
        check("async_s_level", 64'(lvl0), 64'd0);
        check("async_s_ready", 64'(bus0.s_in_ready), 64'd1);
        check("async_g_ready", 64'(bus0.g_axis_TREADY), 64'd0);
        check("async_tok_cnt", 64'(cnt0), 64'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        bus0.y_axis_TREADY = 1'b1;

        // Fill to full, then run three laps of 64 tokens through the pointer wrap.
        pulse_reset();
        for (int k = 0; k < 64; k++) send_s(tile_t'({$urandom, $urandom}));
        @(negedge clk);
        check("full_level", 64'(lvl0), 64'd64);
        check("full_s_ready", 64'(bus0.s_in_ready), 64'd0);
        @(posedge clk); #1;
        fork
            begin
                for (int k = 64; k < 192; k++) send_s(tile_t'({$urandom, $urandom}));
            end
            begin
                for (int tok = 0; tok < 192; tok++) begin
                    for (int ln = 0; ln < TS; ln++) gx[ln] = 16'(16'h0100 + (tok << 4) + (ln << 3));
                    send_g(gx);
                end
            end
        join
        drain();
        check("wrap_tok_cnt", 64'(cnt0), 64'd192);
        check("wrap_tok_cnt_sat", 64'(cnt1), 64'd192);

        // Back-pressure: one y held stable for 20 cycles while g stays valid.
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            t5_s[k] = tile_t'({$urandom, $urandom});
            send_s(t5_s[k]);
        end
        ga = mk(16'h0100, 16'h0180, 16'hFF00, 16'h0040);
        gb = mk(16'h0200, 16'h0080, 16'h0120, 16'hFE00);
        gc = mk(16'h0300, 16'hFFC0, 16'h0010, 16'h0100);
        bus0.y_axis_TREADY = 1'b0;
        bus0.g_axis_TDATA = ga;
        bus0.g_axis_TVALID = 1'b1;
        @(negedge clk);
        check("bp_first_g_ready", 64'(bus0.g_axis_TREADY), 64'd1);
        @(posedge clk); #1;
        bus0.g_axis_TDATA = gb;
        e = model(t5_s[0], ga);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(bus0.y_axis_TVALID), 64'd1);
            check("bp_hold_data", bus0.y_axis_TDATA, e.wrap);
            check("bp_hold_g_ready", 64'(bus0.g_axis_TREADY), 64'd0);
        end
        @(posedge clk); #1;
        bus0.y_axis_TREADY = 1'b1;
        @(negedge clk);
        check("bp_release_g_ready", 64'(bus0.g_axis_TREADY), 64'd1);
        @(posedge clk); #1;
        bus0.g_axis_TVALID = 1'b0;
        e = model(t5_s[1], gb);
        @(negedge clk);
        check("bp_next_valid", 64'(bus0.y_axis_TVALID), 64'd1);
        check("bp_next_data", bus0.y_axis_TDATA, e.wrap);
        // Simultaneous s and g handshake keeps the level at 1.
        @(posedge clk); #1;
        bus0.s_in_data = tile_t'({$urandom, $urandom});
        bus0.s_in_valid = 1'b1;
        bus0.g_axis_TDATA = gc;
        bus0.g_axis_TVALID = 1'b1;
        @(negedge clk);
        check("sim_both_ready", 64'(bus0.s_in_ready && bus0.g_axis_TREADY), 64'd1);
        @(posedge clk); #1;
        bus0.s_in_valid = 1'b0;
        bus0.g_axis_TVALID = 1'b0;
        e = model(t5_s[2], gc);
        @(negedge clk);
        check("sim_level_kept", 64'(lvl0), 64'd1);
        check("sim_y_data", bus0.y_axis_TDATA, e.wrap);
        @(posedge clk); #1;
        send_g(mk(16'h0100, 16'h0100, 16'h0100, 16'h0100));
        drain();

        // Reset with 10 queued tiles: none of them may ever emerge.
        for (int k = 0; k < 10; k++) send_s(tile_t'({$urandom, $urandom}));
        @(negedge clk);
        check("queued_level", 64'(lvl0), 64'd10);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("queued_rst_level", 64'(lvl0), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus0.g_axis_TDATA = ga;
        bus0.g_axis_TVALID = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("empty_g_stalled", 64'(bus0.g_axis_TREADY), 64'd0);
            check("empty_no_y", 64'(bus0.y_axis_TVALID), 64'd0);
        end
        @(posedge clk); #1;
        s_new = mk(16'h0280, 16'hFD00, 16'h0010, 16'h7000);
        send_s(s_new);
        @(posedge clk); #1;
        bus0.g_axis_TVALID = 1'b0;
        e = model(s_new, ga);
        @(negedge clk);
        check("post_rst_y_valid", 64'(bus0.y_axis_TVALID), 64'd1);
        check("post_rst_y_data", bus0.y_axis_TDATA, e.wrap);
        check("post_rst_y_sat", bus1.y_axis_TDATA, e.sat);
        @(negedge clk);
        check("post_rst_tok_cnt", 64'(cnt0), 64'd1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
